// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : Single-clock SPI initiator. Sends a selector bit plus a 10-bit
//            command word on MOSI and captures an 8-bit MISO reply for rd-data.
// Revision : 1.0
// ============================================================================
module spi_master_ctrl #(
    parameter int MISO_DLY = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RECV  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [3:0] c_WAIT_LAST = 4'(MISO_DLY - 2);
    localparam logic [3:0] c_GAP_LAST  = 4'(IDLE_GAP - 1);
    localparam bit         c_NO_WAIT   = (MISO_DLY == 1);

    logic [2:0] r_state;
    logic [9:0] r_frame;
    logic [7:0] r_rx;
    logic [3:0] r_cnt;
    logic       r_is_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_frame  <= 10'd0;
            r_rx     <= 8'd0;
            r_cnt    <= 4'd0;
            r_is_rd  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame <= {cmd, wdata};
                        r_is_rd <= (cmd == 2'b11);
                        SS_n    <= 1'b0;
                        MOSI    <= cmd[1];
                        busy    <= 1'b1;
                        r_state <= S_SEL;
                    end
                end
                S_SEL: begin
                    MOSI    <= r_frame[9];
                    r_frame <= {r_frame[8:0], 1'b0};
                    r_cnt   <= 4'd0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Count 0..8 emits frame[8]..frame[0]; count 9 closes the word
                    if (r_cnt == 4'd9) begin
                        MOSI  <= 1'b0;
                        r_cnt <= 4'd0;
                        if (r_is_rd) begin
                            r_state <= c_NO_WAIT ? S_RECV : S_WAIT;
                        end else begin
                            SS_n    <= 1'b1;
                            r_state <= S_GAP;
                        end
                    end else begin
                        MOSI    <= r_frame[9];
                        r_frame <= {r_frame[8:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == c_WAIT_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RECV;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RECV: begin
                    r_rx <= {r_rx[6:0], MISO};
                    if (r_cnt == 4'd7) begin
                        SS_n    <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt   <= 4'd0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_IDLE;
                        if (r_is_rd) begin
                            rd_valid <= 1'b1;
                            rd_data  <= r_rx;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    SS_n    <= 1'b1;
                    MOSI    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Brief    : Directed vector bench for spi_master_ctrl (two parameter sets).
// Revision : 1.0
// ============================================================================
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [1:0] cmd;
    logic [7:0] wdata;
    logic       MISO;

    logic       busy_a, done_a, rdv_a, ss_a, mosi_a;
    logic [7:0] rd_a;
    logic       busy_b, done_b, rdv_b, ss_b, mosi_b;
    logic [7:0] rd_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_rd_a, model_rd_b;

    always #5 clk = ~clk;

    spi_master_ctrl #(.MISO_DLY(2), .IDLE_GAP(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .cmd(cmd), .wdata(wdata),
        .busy(busy_a), .done(done_a), .rd_valid(rdv_a), .rd_data(rd_a),
        .SS_n(ss_a), .MOSI(mosi_a), .MISO(MISO)
    );

    spi_master_ctrl #(.MISO_DLY(4), .IDLE_GAP(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmd(cmd), .wdata(wdata),
        .busy(busy_b), .done(done_b), .rd_valid(rdv_b), .rd_data(rd_b),
        .SS_n(ss_b), .MOSI(mosi_b), .MISO(MISO)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [7:0]  wdata;
        logic [7:0]  miso;
        bit          use_b;
        int          idle;
        logic [10:0] exp_mosi;
        int          exp_ss_low;
        int          exp_tail;
        int          exp_done;
        logic        exp_rdv;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_a"}, {19'd0, ss_a, mosi_a, busy_a, done_a, rdv_a, rd_a}, 32'h1000);
        chk({name, "_b"}, {19'd0, ss_b, mosi_b, busy_b, done_b, rdv_b, rd_b}, 32'h1000);
    endtask

    // Launches one frame and watches it until done (bounded).
    task automatic run_frame(input vec_t v);
        logic [10:0] mosi_acc = '0;
        int ss_low = 0, tail = 0, done_at = -1, bad_idle = 0, hold_bad = 0;
        int ts = v.use_b ? 15 : 13;
        logic m_ss, m_mosi, m_done, m_rdv, m_busy;
        logic [7:0] m_rd, model;
        model = v.use_b ? model_rd_b : model_rd_a;
        repeat (v.idle) begin @(posedge clk); #1; end
        cmd = v.cmd;
        wdata = v.wdata;
        if (v.use_b) start_b = 1'b1; else start_a = 1'b1;
        for (int e = 0; e < 60 && done_at < 0; e++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
            start_b = 1'b0;
            m_ss   = v.use_b ? ss_b   : ss_a;
            m_mosi = v.use_b ? mosi_b : mosi_a;
            m_done = v.use_b ? done_b : done_a;
            m_rdv  = v.use_b ? rdv_b  : rdv_a;
            m_busy = v.use_b ? busy_b : busy_a;
            m_rd   = v.use_b ? rd_b   : rd_a;
            if (!m_ss) begin
                ss_low++;
                if (e <= 10) mosi_acc[10-e] = m_mosi;
            end else begin
                if (ss_low > 0) tail++;
                if (m_mosi) bad_idle++;
            end
            if (m_done) begin
                done_at = e;
                chk("rd_valid", {31'd0, m_rdv}, {31'd0, v.exp_rdv});
                chk("rd_data", {24'd0, m_rd}, {24'd0, v.exp_rd});
                chk("busy_at_done", {31'd0, m_busy}, 32'd0);
            end else if (m_rd !== model || m_rdv !== 1'b0 || m_busy !== 1'b1) begin
                hold_bad++;
            end
            begin
                int k = e - ts + 1;
                if (k >= 0 && k <= 7) MISO = v.miso[7-k];
                else MISO = 1'b1;
            end
        end
        MISO = 1'b1;
        chk("mosi_bits", {21'd0, mosi_acc}, {21'd0, v.exp_mosi});
        chk("ss_low_cycles", ss_low, v.exp_ss_low);
        chk("ss_high_tail", tail, v.exp_tail);
        chk("done_edge", done_at, v.exp_done);
        chk("mosi_idle_zero", bad_idle, 0);
        chk("in_frame_hold", hold_bad, 0);
        if (v.exp_rdv) begin
            if (v.use_b) model_rd_b = v.exp_rd; else model_rd_a = v.exp_rd;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int dones, done_at, ss_low;
        bit got;

        vecs[0] = '{2'b00, 8'hA5, 8'h00, 1'b0, 2, 11'b00010100101, 11, 2, 12, 1'b0, 8'h00};
        vecs[1] = '{2'b11, 8'h5A, 8'h3C, 1'b0, 2, 11'b11101011010, 20, 2, 21, 1'b1, 8'h3C};
        vecs[2] = '{2'b01, 8'hF0, 8'hFF, 1'b0, 1, 11'b00111110000, 11, 2, 12, 1'b0, 8'h3C};
        vecs[3] = '{2'b10, 8'h0F, 8'hAA, 1'b0, 3, 11'b11000001111, 11, 2, 12, 1'b0, 8'h3C};
        vecs[4] = '{2'b11, 8'h00, 8'h81, 1'b0, 1, 11'b11100000000, 20, 2, 21, 1'b1, 8'h81};
        vecs[5] = '{2'b11, 8'hFF, 8'h00, 1'b0, 0, 11'b11111111111, 20, 2, 21, 1'b1, 8'h00};
        vecs[6] = '{2'b11, 8'h96, 8'hC3, 1'b1, 2, 11'b11110010110, 22, 4, 25, 1'b1, 8'hC3};
        vecs[7] = '{2'b00, 8'h6B, 8'h55, 1'b1, 0, 11'b00001101011, 11, 4, 14, 1'b0, 8'hC3};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        cmd = 2'b00; wdata = 8'h00; MISO = 1'b1;
        model_rd_a = 8'h00; model_rd_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset_state");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // start held for a whole cmd-01 frame: one frame, relaunch right after done
        @(posedge clk); #1;
        cmd = 2'b01; wdata = 8'h33; start_a = 1'b1;
        dones = 0; done_at = -1; ss_low = 0;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            if (!ss_a) ss_low++;
            if (done_a) begin dones++; done_at = e; end
        end
        chk("held_ss_low", ss_low, 11);
        chk("held_done_count", dones, 1);
        chk("held_done_edge", done_at, 12);
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("held_restart_ss", {31'd0, ss_a}, 32'd0);
        chk("held_restart_busy", {31'd0, busy_a}, 32'd1);
        got = 1'b0;
        for (int e = 0; e < 40 && !got; e++) begin
            @(posedge clk); #1;
            if (done_a) got = 1'b1;
        end
        chk("held_second_done", {31'd0, got}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("held_idle_busy", {31'd0, busy_a}, 32'd0);

        // Reset at T5 of a cmd-10 frame
        cmd = 2'b10; wdata = 8'h0F; start_a = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            @(posedge clk); #1;
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rd_a = 8'h00; model_rd_b = 8'h00;
        chk_reset_vals("midframe_reset");
        @(posedge clk); #1;
        chk("midframe_no_done", {30'd0, done_a, ss_a}, 32'd1);
        v = '{2'b00, 8'h3C, 8'h00, 1'b0, 0, 11'b00000111100, 11, 2, 12, 1'b0, 8'h00};
        run_frame(v);

        // rst and start on the same edge
        @(posedge clk); #1;
        cmd = 2'b11; wdata = 8'hC0; start_a = 1'b1; start_b = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        chk_reset_vals("rst_and_start");
        @(posedge clk); #1;
        chk("rst_start_no_frame", {29'd0, ss_a, busy_a, ss_b & ~busy_b}, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
